pcs_40g_tx_sched: RTL and testbench
===================================

// Module: pcs_40g_tx_sched
// PURPOSE
//  Transmit-side slot scheduler for the 40GBASE-R PCS TX datapath.
//  - Decides, each cycle, which 66b block slot the datapath fills: MAC data, an alignment marker (AM) on all lanes, or nothing.
//  - Empty slots are gearbox slips and PMA stalls.
//  - Drives ready_o back to the MAC and the strobes that steer the encoder/scrambler/AM-insert stages.
// PARAMETERS
//  LANE_N     4      PCS lanes; an AM is inserted on all lanes in the same slot
//  AM_GAP     16383  data slots per lane between two AM slots (min 1)
//  GB_PERIOD  32     cycles per gearbox period; last cycle of each period is a slip (min 2)
//  BLK_CNT_W  $clog2(AM_GAP+1)  slot counter width
//  GB_CNT_W   $clog2(GB_PERIOD) gearbox counter width
// PORTS
//  clk          in   1       datapath clock
//  nreset       in   1       asynchronous active-low reset
//  en_i         in   1       link enable from management; 0 = idle
//  pma_ready_i  in   1       PMA can accept data this cycle; 0 = full stall
//  ready_o      out  1       MAC block in data_i is consumed this cycle
//  am_v_o       out  1       datapath emits AM on all LANE_N lanes this cycle
//  slip_o       out  1       gearbox slip cycle: no block consumed or emitted
//  run_o        out  1       scheduler active (not IDLE)
//  am_cnt_o     out  16      number of AM slots issued since en_i rose; wraps
// BEHAVIOUR
//  - Reset (async, nreset=0): state IDLE; blk_cnt=0, gb_cnt=0, am_cnt_o=0.
//    All outputs 0, including while nreset is low.
//  - Outputs are decoded only from registered state (no input->output comb path).
//    A response to en_i/pma_ready_i appears the cycle after the input is sampled.
//  - FSM states:
//    - IDLE: entered on reset and whenever en_i is sampled 0 (from any state).
//      Clears blk_cnt, gb_cnt, am_cnt_o.
//    - IDLE->RUN: en_i sampled 1. The first RUN cycle has blk_cnt=0 and gb_cnt=0,
//      so the first active slot is an AM.
//    - RUN->HOLD: pma_ready_i sampled 0. HOLD->RUN: pma_ready_i sampled 1.
//      In HOLD, blk_cnt, gb_cnt and am_cnt_o freeze; ready_o=am_v_o=slip_o=0; run_o=1.
//  - gb_cnt in RUN: increments every cycle, wraps GB_PERIOD-1 -> 0.
//    slip_o = RUN & gb_cnt==GB_PERIOD-1.
//  - blk_cnt in RUN: advances only on non-slip cycles, wraps AM_GAP -> 0.
//    Slot 0 = AM; slots 1..AM_GAP = data.
//  - Slot decode:
//    - am_v_o  = RUN & !slip & blk_cnt==0
//    - ready_o = RUN & !slip & blk_cnt!=0
//    - am_v_o, ready_o and slip_o are mutually exclusive.
//  - AM due on a slip cycle: the slip wins and the AM slot is deferred to the next non-slip RUN cycle.
//    Data is never consumed ahead of a pending AM.
//  - am_cnt_o increments (mod 2^16) in the cycle after each am_v_o=1 cycle.
//  - en_i dropped mid-period: no flush. The next cycle is IDLE with all outputs 0.
//    A later re-enable restarts with an AM.
//  - Async reset mid-RUN: immediate return to reset values; no partial slot outstanding.
//  - Long-run ratio in steady RUN with no HOLD:
//    - per GB_PERIOD cycles: exactly GB_PERIOD-1 slots and 1 slip
//    - per AM_GAP+1 slots: exactly 1 AM
// TESTING  (bench uses AM_GAP=4, GB_PERIOD=8 unless noted)
//  1 Reset then en_i=1 at cycle 0, pma_ready_i=1 -> cycle 1 am_v_o=1; cycles 2-5 ready_o=1;
//    cycle 6 am_v_o=1; cycle 7 ready_o=1; cycle 8 slip_o=1 (gb wrap); am_cnt_o=2 at cycle 7.
//  2 Free-run 800 cycles -> exactly 100 slip cycles, 140 AM cycles, 560 ready cycles;
//    no cycle has more than one of {ready_o, am_v_o, slip_o} high.
//  3 AM due on a slip (GB_PERIOD=6, AM_GAP=4) -> in the cycle where blk_cnt==0 and gb_cnt==5:
//    am_v_o=0, slip_o=1; am_v_o=1 the next cycle; ready_o stays 0 for both cycles.
//  4 pma_ready_i=0 for 3 cycles mid-data at blk_cnt=2 -> 3 cycles with all strobes 0, run_o=1;
//    resumes with ready_o=1 and the same blk_cnt/gb_cnt as before the stall.
//  5 en_i=0 at blk_cnt=3 -> next cycle run_o=ready_o=0, am_cnt_o=0;
//    re-enable -> first active cycle am_v_o=1.
//  6 nreset pulsed low mid-RUN (async, between edges) -> all outputs 0 immediately;
//    after release with en_i=1, restart behaves as in scenario 1.

Source files
------------

// File: rtl/pcs_40g_tx_sched.sv
// 40GBASE-R PCS TX slot scheduler: picks MAC data, an all-lane alignment marker, or
// an empty slot (gearbox slip / PMA stall) each cycle. Outputs are registered.
//
// state | meaning
// IDLE  | link disabled; counters cleared, all strobes low
// RUN   | slots issued: AM at blk_cnt==0, data otherwise, slip at gb_cnt==GB_PERIOD-1
// HOLD  | PMA stall; counters frozen, run_o only
module pcs_40g_tx_sched #(
  parameter int LANE_N    = 4,
  parameter int AM_GAP    = 16383,
  parameter int GB_PERIOD = 32,
  parameter int BLK_CNT_W = $clog2(AM_GAP + 1),
  parameter int GB_CNT_W  = $clog2(GB_PERIOD)
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        en_i,
  input  logic        pma_ready_i,
  output logic        ready_o,
  output logic        am_v_o,
  output logic        slip_o,
  output logic        run_o,
  output logic [15:0] am_cnt_o
);

  if (LANE_N < 1 || AM_GAP < 1 || GB_PERIOD < 2) begin : g_param_check
    $error("pcs_40g_tx_sched: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [GB_CNT_W-1:0]  GB_LAST  = GB_CNT_W'(GB_PERIOD - 1);
  localparam logic [BLK_CNT_W-1:0] BLK_LAST = BLK_CNT_W'(AM_GAP);

  state_t               state, state_nxt;
  logic [GB_CNT_W-1:0]  gb_cnt, gb_nxt;
  logic [BLK_CNT_W-1:0] blk_cnt, blk_nxt;
  logic [15:0]          am_cnt_nxt;
  logic                 slip_nxt, am_nxt, ready_nxt, run_nxt;

  // slip_o/am_v_o already describe the current RUN slot, so they drive the advance decisions
  always_comb begin
    state_nxt  = state;
    gb_nxt     = gb_cnt;
    blk_nxt    = blk_cnt;
    am_cnt_nxt = am_cnt_o;
    if (!en_i) begin
      state_nxt  = IDLE;
      gb_nxt     = '0;
      blk_nxt    = '0;
      am_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt  = RUN;
          gb_nxt     = '0;
          blk_nxt    = '0;
          am_cnt_nxt = '0;
        end
        RUN: begin
          gb_nxt = (gb_cnt == GB_LAST) ? '0 : gb_cnt + GB_CNT_W'(1);
          if (!slip_o)
            blk_nxt = (blk_cnt == BLK_LAST) ? '0 : blk_cnt + BLK_CNT_W'(1);
          if (am_v_o)
            am_cnt_nxt = am_cnt_o + 16'd1;
          if (!pma_ready_i)
            state_nxt = HOLD;
        end
        HOLD: begin
          if (pma_ready_i)
            state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A pending AM on a slip cycle simply waits: blk_cnt stays 0 through the slip
  always_comb begin
    run_nxt   = (state_nxt != IDLE);
    slip_nxt  = (state_nxt == RUN) && (gb_nxt == GB_LAST);
    am_nxt    = (state_nxt == RUN) && !slip_nxt && (blk_nxt == '0);
    ready_nxt = (state_nxt == RUN) && !slip_nxt && (blk_nxt != '0);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      gb_cnt   <= '0;
      blk_cnt  <= '0;
      am_cnt_o <= '0;
      run_o    <= 1'b0;
      slip_o   <= 1'b0;
      am_v_o   <= 1'b0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gb_cnt   <= gb_nxt;
      blk_cnt  <= blk_nxt;
      am_cnt_o <= am_cnt_nxt;
      run_o    <= run_nxt;
      slip_o   <= slip_nxt;
      am_v_o   <= am_nxt;
      ready_o  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_pcs_40g_tx_sched.sv
// Directed bench for pcs_40g_tx_sched: a main instance (AM_GAP=4, GB_PERIOD=8) and a
// second one (GB_PERIOD=6) for the AM-on-slip deferral.
module tb_pcs_40g_tx_sched;

  logic        clk = 1'b0;
  logic        nreset;
  logic        en_i;
  logic        pma_ready_i;
  logic        ready_o, am_v_o, slip_o, run_o;
  logic [15:0] am_cnt_o;
  logic        ready6, am6, slip6, run6;
  logic [15:0] am_cnt6;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pcs_40g_tx_sched #(.LANE_N(4), .AM_GAP(4), .GB_PERIOD(8)) u_dut (
    .clk(clk), .nreset(nreset), .en_i(en_i), .pma_ready_i(pma_ready_i),
    .ready_o(ready_o), .am_v_o(am_v_o), .slip_o(slip_o), .run_o(run_o),
    .am_cnt_o(am_cnt_o)
  );

  pcs_40g_tx_sched #(.LANE_N(4), .AM_GAP(4), .GB_PERIOD(6)) u_dut6 (
    .clk(clk), .nreset(nreset), .en_i(en_i), .pma_ready_i(pma_ready_i),
    .ready_o(ready6), .am_v_o(am6), .slip_o(slip6), .run_o(run6),
    .am_cnt_o(am_cnt6)
  );

  // One row per cycle: inputs sampled at the edge, outputs expected just after it
  typedef struct {
    logic        en;
    logic        pma;
    logic [19:0] exp;  // {ready, am_v, slip, run, am_cnt}
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(logic en, logic pma, logic r, logic a, logic s,
                              logic run, logic [15:0] cnt);
    vec_t v;
    v.en  = en;
    v.pma = pma;
    v.exp = {r, a, s, run, cnt};
    return v;
  endfunction

  task automatic step(input logic en, input logic pma);
    en_i        = en;
    pma_ready_i = pma;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got r/a/s/run=%b cnt=%0d, want r/a/s/run=%b cnt=%0d",
               name, act[19:16], act[15:0], exp[19:16], exp[15:0]);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {ready_o, am_v_o, slip_o, run_o, am_cnt_o};
  endfunction

  function automatic logic [19:0] outs6();
    return {ready6, am6, slip6, run6, am_cnt6};
  endfunction

  initial begin
    // Scenario 1 (cycles 1-14), PMA stall at blk 2 (15-20), en drop at blk 3 and re-enable (25-27)
    tbl[0]  = mk(1, 1, 0, 1, 0, 1, 0);
    tbl[1]  = mk(1, 1, 1, 0, 0, 1, 1);
    tbl[2]  = mk(1, 1, 1, 0, 0, 1, 1);
    tbl[3]  = mk(1, 1, 1, 0, 0, 1, 1);
    tbl[4]  = mk(1, 1, 1, 0, 0, 1, 1);
    tbl[5]  = mk(1, 1, 0, 1, 0, 1, 1);
    tbl[6]  = mk(1, 1, 1, 0, 0, 1, 2);
    tbl[7]  = mk(1, 1, 0, 0, 1, 1, 2);
    tbl[8]  = mk(1, 1, 1, 0, 0, 1, 2);
    tbl[9]  = mk(1, 1, 1, 0, 0, 1, 2);
    tbl[10] = mk(1, 1, 1, 0, 0, 1, 2);
    tbl[11] = mk(1, 1, 0, 1, 0, 1, 2);
    tbl[12] = mk(1, 1, 1, 0, 0, 1, 3);
    tbl[13] = mk(1, 1, 1, 0, 0, 1, 3);
    tbl[14] = mk(1, 0, 0, 0, 0, 1, 3);
    tbl[15] = mk(1, 0, 0, 0, 0, 1, 3);
    tbl[16] = mk(1, 0, 0, 0, 0, 1, 3);
    tbl[17] = mk(1, 1, 1, 0, 0, 1, 3);
    tbl[18] = mk(1, 1, 0, 0, 1, 1, 3);
    tbl[19] = mk(1, 1, 1, 0, 0, 1, 3);
    tbl[20] = mk(1, 1, 0, 1, 0, 1, 3);
    tbl[21] = mk(1, 1, 1, 0, 0, 1, 4);
    tbl[22] = mk(1, 1, 1, 0, 0, 1, 4);
    tbl[23] = mk(1, 1, 1, 0, 0, 1, 4);
    tbl[24] = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[25] = mk(1, 1, 0, 1, 0, 1, 0);
    tbl[26] = mk(1, 1, 1, 0, 0, 1, 1);

    nreset      = 1'b0;
    en_i        = 1'b0;
    pma_ready_i = 1'b1;
    #1;
    chk("reset_async", outs(), 20'h0);
    @(posedge clk);
    #1;
    chk("reset_held", outs(), 20'h0);
    @(negedge clk);
    nreset = 1'b1;
    step(0, 1);
    chk("idle_en0", outs(), 20'h0);

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].en, tbl[i].pma);
      chk($sformatf("tbl_cycle%0d", i + 1), outs(), tbl[i].exp);
    end

    // Scenario 2: free-run 800 cycles
    begin
      int n_slip, n_am, n_rdy, n_multi;
      n_slip = 0; n_am = 0; n_rdy = 0; n_multi = 0;
      step(0, 1);
      for (int i = 0; i < 800; i++) begin
        step(1, 1);
        n_slip += int'(slip_o);
        n_am   += int'(am_v_o);
        n_rdy  += int'(ready_o);
        if (int'(slip_o) + int'(am_v_o) + int'(ready_o) > 1) n_multi++;
      end
      chk_int("free_slip", n_slip, 100);
      chk_int("free_am", n_am, 140);
      chk_int("free_ready", n_rdy, 560);
      chk_int("free_exclusive", n_multi, 0);
      chk_int("free_am_cnt", int'(am_cnt_o), 140);
    end

    // Scenario 3: GB_PERIOD=6 instance, AM due on slip at cycle 6
    step(0, 1);
    for (int c = 1; c <= 7; c++) begin
      step(1, 1);
      if (c == 5) chk("am_slip_c5", outs6(), {1'b1, 1'b0, 1'b0, 1'b1, 16'd1});
      if (c == 6) chk("am_slip_c6", outs6(), {1'b0, 1'b0, 1'b1, 1'b1, 16'd1});
      if (c == 7) chk("am_slip_c7", outs6(), {1'b0, 1'b1, 1'b0, 1'b1, 16'd1});
    end
    step(1, 1);
    chk("am_slip_c8", outs6(), {1'b1, 1'b0, 1'b0, 1'b1, 16'd2});

    // Scenario 6: async reset between edges mid-RUN, then restart like scenario 1
    step(1, 1);
    step(1, 1);
    #2;
    nreset = 1'b0;
    #1;
    chk("mid_reset_async", outs(), 20'h0);
    en_i = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].en, tbl[i].pma);
      chk($sformatf("restart_cycle%0d", i + 1), outs(), tbl[i].exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
